// File: rtl/fsk_pkg.sv
// Shared constants and FSM state type for the PS/FSK modulator.
// Frame length depends on FSK_PARITY_EN (adds one even-parity bit).
package fsk_pkg;

  localparam int WORD_W_DEF      = 16;
  localparam int FRAME_LEN_NOPAR = WORD_W_DEF;
  localparam int FRAME_LEN_PAR   = WORD_W_DEF + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_PARITY = 2'd3
  } fsk_state_e;

endpackage

// File: rtl/edge_det.sv
// One-bit rising-edge detector in the sys_clk domain.
// The strobe is high in the cycle the input is first seen high.
module edge_det (
  input  logic sys_clk,
  input  logic sys_clk_rst,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge sys_clk or posedge sys_clk_rst) begin
    if (sys_clk_rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/ps_fsk_mod.sv
// Parallel-to-serial FSK modulator: one-word holding buffer, MSB-first shifter, 2:1 carrier.
// Define FSK_PARITY_EN to append an even-parity bit to every frame.
//
// Handshake: data_in is accepted on a sys_clk edge where data_valid && data_ready;
// data_valid while data_ready is low has no effect, and data_in need not be held.
module ps_fsk_mod
  import fsk_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_clk_rst,
  input  logic              ps_clk,
  input  logic              fsk_clk,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx_bit,
  output logic              fsk_out,
  output logic              tx_active,
  output logic              frame_done,
  output fsk_state_e        dbg_state
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WORD_W - 1);

  fsk_state_e        state_q;
  logic [WORD_W-1:0] hold_q;
  logic              hold_full_q;
  logic [WORD_W-1:0] shift_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              tx_bit_q;
  logic              tx_active_q;
  logic              frame_done_q;
  logic              phase_q;
  logic              fsk_q;
`ifdef FSK_PARITY_EN
  logic              parity_q;
`endif

  logic ps_rise;
  logic fsk_rise;
  logic accept;
  logic frame_end;

  edge_det u_ps_edge (
    .sys_clk     (sys_clk),
    .sys_clk_rst (sys_clk_rst),
    .sig_i       (ps_clk),
    .rise_o      (ps_rise)
  );

  edge_det u_fsk_edge (
    .sys_clk     (sys_clk),
    .sys_clk_rst (sys_clk_rst),
    .sig_i       (fsk_clk),
    .rise_o      (fsk_rise)
  );

  assign accept = data_valid & ~hold_full_q;

  // The ps_rise that closes the last bit period of the frame.
`ifdef FSK_PARITY_EN
  assign frame_end = ps_rise && (state_q == ST_PARITY);
`else
  assign frame_end = ps_rise && (state_q == ST_SHIFT) && (bit_cnt_q == LAST_DATA);
`endif

  always_ff @(posedge sys_clk or posedge sys_clk_rst) begin
    if (sys_clk_rst) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      tx_bit_q     <= 1'b0;
      tx_active_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef FSK_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      if (accept) begin
        hold_q      <= data_in;
        hold_full_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (hold_full_q) begin
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
`ifdef FSK_PARITY_EN
            parity_q    <= ^hold_q;
`endif
            state_q     <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (ps_rise) begin
            tx_bit_q    <= shift_q[WORD_W-1];
            shift_q     <= shift_q << 1;
            bit_cnt_q   <= '0;
            tx_active_q <= 1'b1;
            state_q     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ps_rise) begin
            if (bit_cnt_q != LAST_DATA) begin
              tx_bit_q  <= shift_q[WORD_W-1];
              shift_q   <= shift_q << 1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
`ifdef FSK_PARITY_EN
            else begin
              tx_bit_q  <= parity_q;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              state_q   <= ST_PARITY;
            end
`endif
          end
        end
`ifdef FSK_PARITY_EN
        ST_PARITY: begin
        end
`endif
        default: state_q <= ST_IDLE;
      endcase

      // Frame end overrides the per-state updates above; a queued word starts with no gap.
      if (frame_end) begin
        frame_done_q <= 1'b1;
        if (hold_full_q) begin
          tx_bit_q    <= hold_q[WORD_W-1];
          shift_q     <= hold_q << 1;
          hold_full_q <= 1'b0;
          bit_cnt_q   <= '0;
`ifdef FSK_PARITY_EN
          parity_q    <= ^hold_q;
`endif
          state_q     <= ST_SHIFT;
        end else begin
          tx_bit_q    <= 1'b0;
          tx_active_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      end
    end
  end

  // Carrier reads tx_bit_q before this cycle's bit update, and never resets at bit boundaries.
  always_ff @(posedge sys_clk or posedge sys_clk_rst) begin
    if (sys_clk_rst) begin
      phase_q <= 1'b0;
      fsk_q   <= 1'b0;
    end else if (!tx_active_q) begin
      phase_q <= 1'b0;
      fsk_q   <= 1'b0;
    end else if (fsk_rise) begin
      phase_q <= ~phase_q;
      if (tx_bit_q || phase_q) begin
        fsk_q <= ~fsk_q;
      end
    end
  end

  assign data_ready = ~hold_full_q;
  assign tx_bit     = tx_bit_q;
  assign fsk_out    = fsk_q;
  assign tx_active  = tx_active_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps_fsk_mod.sv
// Scoreboard bench for ps_fsk_mod: 64 sys_clk per bit, 16 fsk_clk periods per bit.
// Honours FSK_PARITY_EN to expect the extra parity bit.
`timescale 1ns/1ps
module tb_ps_fsk_mod;
  import fsk_pkg::*;

  localparam int W = WORD_W_DEF;

  logic         sys_clk = 1'b0;
  logic         sys_clk_rst;
  logic         ps_clk;
  logic         fsk_clk;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic         tx_bit;
  logic         fsk_out;
  logic         tx_active;
  logic         frame_done;
  fsk_state_e   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [0:0] exp_q[$];

  logic       div_en = 1'b0;
  logic [5:0] dcnt   = '0;

  int   done_cnt = 0;
  int   fall_cnt = 0;
  int   rise_cnt = 0;
  logic have_bit = 1'b0;
  logic cur_bit  = 1'b0;
  logic fsk_prev = 1'b0;
  logic fd_prev  = 1'b0;
  logic ta_prev  = 1'b0;

  ps_fsk_mod #(.WORD_W(W)) dut (
    .sys_clk     (sys_clk),
    .sys_clk_rst (sys_clk_rst),
    .ps_clk      (ps_clk),
    .fsk_clk     (fsk_clk),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .tx_bit      (tx_bit),
    .fsk_out     (fsk_out),
    .tx_active   (tx_active),
    .frame_done  (frame_done),
    .dbg_state   (dbg_state)
  );

  // Clock / divider block: ps_clk and fsk_clk rise together at dcnt == 32.
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (div_en) begin
      dcnt    = dcnt + 6'd1;
      ps_clk  = dcnt[5];
      fsk_clk = ~dcnt[1];
    end else begin
      dcnt    = '0;
      ps_clk  = 1'b0;
      fsk_clk = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef FSK_PARITY_EN
    exp_q.push_back(^w);
`endif
  endtask

  task automatic send_word(input logic [W-1:0] w);
    int t;
    t = 0;
    @(negedge sys_clk);
    while (!data_ready && t < 3000) begin
      @(negedge sys_clk);
      t++;
    end
    check("ready_before_send", data_ready, 1);
    data_in    = w;
    data_valid = 1'b1;
    @(negedge sys_clk);
    data_valid = 1'b0;
    push_word(w);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((tx_active || !data_ready || exp_q.size() != 0 || dbg_state != ST_IDLE) && t < 6000) begin
      @(negedge sys_clk);
      t++;
    end
    check("idle_reached", (t < 6000), 1);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_tx_bit"},     tx_bit,     0);
    check({tag, "_fsk_out"},    fsk_out,    0);
    check({tag, "_tx_active"},  tx_active,  0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_data_ready"}, data_ready, 1);
    check({tag, "_state"},      dbg_state,  ST_IDLE);
  endtask

  // Monitor: tx_bit checked mid-bit against the queue, carrier rises counted per bit window.
  always @(posedge sys_clk) begin
    #2;
    if (sys_clk_rst) begin
      have_bit = 1'b0;
      rise_cnt = 0;
      fsk_prev = 1'b0;
      fd_prev  = 1'b0;
      ta_prev  = 1'b0;
    end else begin
      if (fsk_out && !fsk_prev) rise_cnt++;
      fsk_prev = fsk_out;
      if (frame_done) begin
        done_cnt++;
        check("frame_done_single", fd_prev, 0);
      end
      fd_prev = frame_done;
      if (ta_prev && !tx_active) fall_cnt++;
      ta_prev = tx_active;
      if (div_en && dcnt == 6'd32) begin
        if (have_bit) check("carrier_cycles", rise_cnt, cur_bit ? 8 : 4);
        have_bit = 1'b0;
        rise_cnt = 0;
      end
      if (div_en && dcnt == 6'd0 && tx_active) begin
        check("bit_available", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur_bit  = exp_q.pop_front();
          have_bit = 1'b1;
          check("tx_bit", tx_bit, cur_bit);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int f0;
    sys_clk_rst = 1'b1;
    data_valid  = 1'b0;
    data_in     = '0;
    ps_clk      = 1'b0;
    fsk_clk     = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2;
    check_quiet("reset");
    @(negedge sys_clk);
    sys_clk_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    div_en = 1'b1;

    // Single frame, MSB first.
    d0 = done_cnt; f0 = fall_cnt;
    send_word(16'h8001);
    wait_idle();
    check("ser_frames", done_cnt - d0, 1);
    check("ser_falls",  fall_cnt - f0, 1);
    check_quiet("ser_end");

    // Back-to-back: second word queued while the first is on the line.
    d0 = done_cnt; f0 = fall_cnt;
    send_word(16'hFFFF);
    send_word(16'h0000);
    repeat (5) @(negedge sys_clk);
    check("b2b_ready_low", data_ready, 0);
    wait_idle();
    check("b2b_frames", done_cnt - d0, 2);
    check("b2b_falls",  fall_cnt - f0, 1);

    // Overflow: 0xDEAD offered while the buffer is full must be ignored.
    d0 = done_cnt; f0 = fall_cnt;
    send_word(16'h1111);
    send_word(16'h5A3C);
    data_in    = 16'hDEAD;
    data_valid = 1'b1;
    repeat (200) @(negedge sys_clk);
    check("ovf_ready_low", data_ready, 0);
    data_valid = 1'b0;
    wait_idle();
    check("ovf_frames", done_cnt - d0, 2);
    check("ovf_falls",  fall_cnt - f0, 1);

    // Reset mid-frame aborts, then a normal frame follows.
    d0 = done_cnt;
    send_word(16'hA5A5);
    repeat (300) @(negedge sys_clk);
    check("mid_active", tx_active, 1);
    sys_clk_rst = 1'b1;
    div_en      = 1'b0;
    exp_q.delete();
    @(posedge sys_clk);
    #2;
    check_quiet("abort");
    check("abort_frames", done_cnt - d0, 0);
    @(negedge sys_clk);
    sys_clk_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    div_en = 1'b1;
    d0 = done_cnt; f0 = fall_cnt;
    send_word(16'h1234);
    wait_idle();
    check("post_rst_frames", done_cnt - d0, 1);
    check("post_rst_falls",  fall_cnt - f0, 1);

`ifdef FSK_PARITY_EN
    d0 = done_cnt;
    send_word(16'h0007);
    wait_idle();
    send_word(16'h0003);
    wait_idle();
    check("par_frames", done_cnt - d0, 2);
`endif

    check_quiet("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
